// File: rtl/sensor_scan_pkg.sv
// rtl/sensor_scan_pkg.sv - shared constants and state encoding for the sensor scan controller
package sensor_scan_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_SAMPLE = 2'd2;
  localparam state_t ST_NEXT   = 2'd3;
endpackage

// File: rtl/sensor_scan_ctrl_if.sv
// rtl/sensor_scan_ctrl_if.sv - mux control and debounced level bundle of the sensor scan controller
interface sensor_scan_ctrl_if;
  import sensor_scan_pkg::*;

  logic              enable;
  logic              mux_out;
  logic [SEL_W-1:0]  sel;
  logic [NUM_CH-1:0] levels;
  logic              valid;
  logic              changed;
  logic              scan_done;

  modport master (input enable, mux_out, output sel, levels, valid, changed, scan_done);
  modport slave  (output enable, mux_out, input sel, levels, valid, changed, scan_done);
endinterface

// File: rtl/scan_debounce_bit.sv
// rtl/scan_debounce_bit.sv - per-channel debounce: level flips after DEBOUNCE_COUNT differing samples
module scan_debounce_bit #(
  parameter int DEBOUNCE_COUNT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_en,
  input  logic first_scan,
  input  logic din,
  output logic level,
  output logic flip
);
  localparam int CW = $clog2(DEBOUNCE_COUNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_COUNT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
      flip  <= 1'b0;
    end else begin
      flip <= 1'b0;
      if (sample_en) begin
        // first scan loads directly; flip only reports a bit that actually rose from reset
        if (first_scan) begin
          level <= din;
          cnt   <= '0;
          flip  <= din ^ level;
        end else if (din == level) begin
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          level <= din;
          cnt   <= '0;
          flip  <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/sensor_scan_ctrl.sv
// rtl/sensor_scan_ctrl.sv - round-robin 4:1 sensor mux scanner with settle time and per-channel debounce
module sensor_scan_ctrl
  import sensor_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_COUNT = 3
) (
  input logic                clk,
  input logic                rst_n,
  sensor_scan_ctrl_if.master bus
);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W-1:0] CH_LAST     = SEL_W'(NUM_CH - 1);

  state_t            state, state_nxt;
  logic [SW-1:0]     scnt;
  logic [SEL_W-1:0]  sel;
  logic              valid;
  logic              sampling;
  logic              scan_done;
  logic [NUM_CH-1:0] levels;
  logic [NUM_CH-1:0] flips;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.enable) state_nxt = ST_SETTLE;
      ST_SETTLE: if (scnt == SETTLE_LAST) state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = ST_NEXT;
      ST_NEXT:   state_nxt = bus.enable ? ST_SETTLE : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    sampling  = (state == ST_SAMPLE);
    scan_done = (state == ST_NEXT) && (sel == CH_LAST);
  end

  // scnt is zero whenever SETTLE is entered, so no explicit load on entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scnt  <= '0;
      sel   <= '0;
      valid <= 1'b0;
    end else begin
      scnt <= (state == ST_SETTLE) ? scnt + 1'b1 : '0;
      if (state == ST_NEXT) sel <= sel + 1'b1;
      if (sampling && sel == CH_LAST) valid <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    scan_debounce_bit #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_bit (
      .clk        (clk),
      .rst_n      (rst_n),
      .sample_en  (sampling && sel == SEL_W'(i)),
      .first_scan (!valid),
      .din        (bus.mux_out),
      .level      (levels[i]),
      .flip       (flips[i])
    );
  end

  assign bus.sel       = sel;
  assign bus.levels    = levels;
  assign bus.valid     = valid;
  assign bus.changed   = |flips;
  assign bus.scan_done = scan_done;
endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// tb/tb_sensor_scan_ctrl.sv - directed and random bench for sensor_scan_ctrl at two parameter sets
module tb_sensor_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       en = 1'b1;
  logic [3:0] a = 4'b0000;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sensor_scan_ctrl_if bd ();
  sensor_scan_ctrl_if bf ();
  assign bd.enable  = en;
  assign bf.enable  = en;
  assign bd.mux_out = a[bd.sel];
  assign bf.mux_out = a[bf.sel];

  sensor_scan_ctrl u_dut (.clk(clk), .rst_n(rst_n), .bus(bd));
  sensor_scan_ctrl #(.SETTLE_CYCLES(1), .DEBOUNCE_COUNT(1)) u_fast (.clk(clk), .rst_n(rst_n), .bus(bf));

  wire [15:0] obs_d = {7'd0, bd.sel, bd.levels, bd.valid, bd.changed, bd.scan_done};
  wire [15:0] obs_f = {7'd0, bf.sel, bf.levels, bf.valid, bf.changed, bf.scan_done};

  // reference model: each channel visit is S settle cycles, one sample, one advance
  int         sk [2] = '{4, 1};
  int         dk [2] = '{3, 1};
  bit         mrun [2];
  int         mphase [2];
  logic [1:0] msel [2];
  logic [3:0] mlev [2];
  int         mcnt [2][4];
  logic       mvalid [2], mchg [2], mdone [2];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mrun[k] = 0; mphase[k] = 0; msel[k] = 2'd0; mlev[k] = 4'd0;
      mvalid[k] = 1'b0; mchg[k] = 1'b0; mdone[k] = 1'b0;
      for (int c = 0; c < 4; c++) mcnt[k][c] = 0;
    end
  endtask

  task automatic model_step(input int k);
    int   ch;
    logic v, fl;
    mchg[k] = 1'b0;
    mdone[k] = 1'b0;
    if (!mrun[k]) begin
      if (en) begin mrun[k] = 1; mphase[k] = 0; end
    end else if (mphase[k] == sk[k]) begin
      ch = int'(msel[k]);
      v = a[ch];
      fl = 1'b0;
      if (!mvalid[k]) begin
        fl = (v != mlev[k][ch]); mlev[k][ch] = v; mcnt[k][ch] = 0;
      end else if (v == mlev[k][ch]) begin
        mcnt[k][ch] = 0;
      end else if (mcnt[k][ch] == dk[k] - 1) begin
        mlev[k][ch] = v; mcnt[k][ch] = 0; fl = 1'b1;
      end else begin
        mcnt[k][ch] = mcnt[k][ch] + 1;
      end
      mchg[k] = fl;
      if (ch == 3) begin mdone[k] = 1'b1; mvalid[k] = 1'b1; end
      mphase[k] = mphase[k] + 1;
    end else if (mphase[k] == sk[k] + 1) begin
      msel[k] = msel[k] + 2'd1;
      if (en) mphase[k] = 0;
      else mrun[k] = 0;
    end else begin
      mphase[k] = mphase[k] + 1;
    end
  endtask

  function automatic logic [15:0] exp_vec(input int k);
    return {7'd0, msel[k], mlev[k], mvalid[k], mchg[k], mdone[k]};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_n) begin
      model_step(0);
      model_step(1);
    end
    chk("cycle_default", obs_d, exp_vec(0));
    chk("cycle_fast", obs_f, exp_vec(1));
  endtask

  task automatic wait_sel(input logic [1:0] v);
    int n = 0;
    while (bd.sel !== v && n < 100) begin tick(); n++; end
    chk("wait_sel_bound", 16'(n < 100), 16'd1);
  endtask

  initial begin
    int n, nf, h1, h2, nchg, idx;
    model_reset();
    a = 4'b1010;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("reset_default", obs_d, 16'd0);
    chk("reset_fast", obs_f, 16'd0);
    #4 rst_n = 1'b1;

    // first scan with a static pattern
    n = 0; nf = 0; h1 = 0; h2 = 0;
    while (n < 40) begin
      tick(); n++;
      if (bd.sel == 2'd1) h1++;
      if (bd.sel == 2'd2) h2++;
      if (bf.scan_done && nf == 0) nf = n;
      if (bd.scan_done) break;
    end
    chk("scan_len_default", 16'(n), 16'd24);
    chk("scan_len_fast", 16'(nf), 16'd12);
    chk("hold_ch1", 16'(h1), 16'd6);
    chk("hold_ch2", 16'(h2), 16'd6);
    chk("first_levels", 16'(bd.levels), 16'b1010);
    chk("first_valid_changed", {14'd0, bd.valid, bd.changed}, 16'b11);
    chk("fast_levels", 16'(bf.levels), 16'b1010);

    // short glitch on channel 0 must not pass the debounce
    nchg = 0;
    a = 4'b1011;
    repeat (48) begin tick(); nchg += int'(bd.changed); end
    a = 4'b1010;
    repeat (24) begin tick(); nchg += int'(bd.changed); end
    chk("glitch_no_change", 16'(nchg), 16'd0);
    chk("glitch_levels", 16'(bd.levels), 16'b1010);
    a = 4'b1011;
    nchg = 0;
    repeat (72) begin tick(); nchg += int'(bd.changed); end
    chk("held_levels", 16'(bd.levels), 16'b1011);
    chk("held_one_pulse", 16'(nchg), 16'd1);

    // drop enable mid-channel, then resume
    wait_sel(2'd2);
    en = 1'b0;
    repeat (12) tick();
    chk("park_sel", 16'(bd.sel), 16'd3);
    repeat (5) tick();
    chk("park_frozen", {7'd0, bd.sel, bd.levels, bd.valid, bd.changed, bd.scan_done}, {7'd0, 2'd3, 4'b1011, 1'b1, 1'b0, 1'b0});
    en = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!bd.scan_done && n < 50);
    chk("resume_ch3", 16'(n), 16'd6);

    // random sensor activity and enable gaps
    repeat (400) begin
      if ($urandom_range(0, 5) == 0) begin
        idx = int'($urandom_range(0, 3));
        a[idx] = ~a[idx];
      end
      en = ($urandom_range(0, 19) != 0);
      tick();
    end

    en = 1'b1;
    a = 4'b1111;
    repeat (100) tick();
    chk("all_high_default", 16'(bd.levels), 16'b1111);
    chk("all_high_fast", 16'(bf.levels), 16'b1111);

    // asynchronous reset in the middle of channel 1 settling
    wait_sel(2'd1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset_default", obs_d, 16'd0);
    chk("async_reset_fast", obs_f, 16'd0);
    repeat (2) tick();
    #4 rst_n = 1'b1;
    repeat (60) begin
      a = 4'($urandom_range(0, 15));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
